// File: rtl/mem_arbiter_if.sv
// Requester ports and BRAM control pins of mem_arbiter, bundled as one bus.
// slave = the arbiter; master = the core requesters plus the BRAM read data.
interface mem_arbiter_if #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
);
    // program loader
    logic              ld_req;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_ack;
    // processor data port
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [31:0]       d_rdata;
    // processor instruction fetch
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    // BRAM pins
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  ld_req, ld_addr, ld_wdata,
        output ld_ack,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_ack, d_err, d_rdata,
        input  if_req, if_addr,
        output if_ack, if_rdata,
        output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output ld_req, ld_addr, ld_wdata,
        input  ld_ack,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_ack, d_err, d_rdata,
        output if_req, if_addr,
        input  if_ack, if_rdata,
        input  mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter (loader > data > fetch) in front of a single
// simple-dual-port BRAM. One access in flight at a time; byte and halfword
// stores are done as an internal read-modify-write.
module mem_arbiter #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RESP, S_RMW} state_e;
    typedef enum logic [1:0] {OWN_LD, OWN_D, OWN_IF} owner_e;

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] idx_q, idx_d;          // latched word index
    logic [1:0]        lane_q, lane_d;        // latched addr[1:0] for the merge
    logic              half_q, half_d;        // RMW merges a halfword, else a byte
    logic [15:0]       rmw_data_q, rmw_data_d;
    logic              err_q, err_d;          // latched misaligned/illegal flag
    logic              rd_q, rd_d;            // access returns read data
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;

    logic [ADDR_W-1:0] ld_idx, d_idx, if_idx;
    logic              sel_ld, sel_d, sel_if;
    logic              d_bad, d_rmw;
    logic [31:0]       rmw_word;
    logic              unused_addr_bits;

    assign ld_idx = bus.ld_addr[ADDR_W+1:2];
    assign d_idx  = bus.d_addr[ADDR_W+1:2];
    assign if_idx = bus.if_addr[ADDR_W+1:2];

    // Upper address bits wrap away; word-only ports ignore the byte offset.
    assign unused_addr_bits = ^{bus.ld_addr[31:ADDR_W+2], bus.ld_addr[1:0],
                                bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                                bus.d_addr[31:ADDR_W+2]};

    // Priority: the loader always wins, fetch only when nobody else asks.
    assign sel_ld = bus.ld_req;
    assign sel_d  = bus.d_req & ~bus.ld_req;
    assign sel_if = bus.if_req & ~bus.ld_req & ~bus.d_req;

    assign d_bad = (bus.d_size == SZ_BAD)
                || (bus.d_size == SZ_HALF && bus.d_addr[0])
                || (bus.d_size == SZ_WORD && bus.d_addr[1:0] != 2'b00);
    assign d_rmw = bus.d_we && !d_bad && bus.d_size != SZ_WORD;

    // State register and latched request fields, synchronously cleared.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_LD;
            idx_q      <= '0;
            lane_q     <= '0;
            half_q     <= 1'b0;
            rmw_data_q <= '0;
            err_q      <= 1'b0;
            rd_q       <= 1'b0;
            d_rdata_q  <= '0;
            if_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            half_q     <= half_d;
            rmw_data_q <= rmw_data_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
            d_rdata_q  <= d_rdata_d;
            if_rdata_q <= if_rdata_d;
        end
    end

    // Next state: grant and latch in IDLE, capture returned data in RESP.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        idx_d      = idx_q;
        lane_d     = lane_q;
        half_d     = half_q;
        rmw_data_d = rmw_data_q;
        err_d      = err_q;
        rd_d       = rd_q;
        d_rdata_d  = d_rdata_q;
        if_rdata_d = if_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (sel_ld) begin
                    state_d = S_RESP;
                    owner_d = OWN_LD;
                    idx_d   = ld_idx;
                    err_d   = 1'b0;
                    rd_d    = 1'b0;
                end else if (sel_d) begin
                    state_d    = d_rmw ? S_RMW : S_RESP;
                    owner_d    = OWN_D;
                    idx_d      = d_idx;
                    lane_d     = bus.d_addr[1:0];
                    half_d     = (bus.d_size == SZ_HALF);
                    rmw_data_d = bus.d_wdata[15:0];
                    err_d      = d_bad;
                    rd_d       = !bus.d_we && !d_bad;
                end else if (sel_if) begin
                    state_d = S_RESP;
                    owner_d = OWN_IF;
                    idx_d   = if_idx;
                    err_d   = 1'b0;
                    rd_d    = 1'b1;
                end
            end
            S_RMW: state_d = S_RESP;
            S_RESP: begin
                state_d = S_IDLE;
                if (owner_q == OWN_D && rd_q) d_rdata_d = bus.mem_rdata;
                if (owner_q == OWN_D && err_q) d_rdata_d = '0;
                if (owner_q == OWN_IF) if_rdata_d = bus.mem_rdata;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: BRAM control per state, acks in RESP, everything low in reset.
    always_comb begin
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_raddr = idx_q;
        bus.mem_waddr = idx_q;
        bus.mem_wdata = '0;
        bus.ld_ack    = 1'b0;
        bus.d_ack     = 1'b0;
        bus.d_err     = 1'b0;
        bus.if_ack    = 1'b0;
        bus.d_rdata   = d_rdata_q;
        bus.if_rdata  = if_rdata_q;

        rmw_word = bus.mem_rdata;
        if (half_q) begin
            if (lane_q[1]) rmw_word[31:16] = rmw_data_q;
            else           rmw_word[15:0]  = rmw_data_q;
        end else begin
            case (lane_q)
                2'd0:    rmw_word[7:0]   = rmw_data_q[7:0];
                2'd1:    rmw_word[15:8]  = rmw_data_q[7:0];
                2'd2:    rmw_word[23:16] = rmw_data_q[7:0];
                default: rmw_word[31:24] = rmw_data_q[7:0];
            endcase
        end

        unique case (state_q)
            S_IDLE: begin
                if (sel_ld) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_raddr = ld_idx;
                    bus.mem_waddr = ld_idx;
                    bus.mem_wdata = bus.ld_wdata;
                end else if (sel_d) begin
                    bus.mem_raddr = d_idx;
                    bus.mem_waddr = d_idx;
                    if (!d_bad && bus.d_we && bus.d_size == SZ_WORD) begin
                        bus.mem_we    = 1'b1;
                        bus.mem_wdata = bus.d_wdata;
                    end else if (!d_bad) begin
                        bus.mem_re = 1'b1;
                    end
                end else if (sel_if) begin
                    bus.mem_re    = 1'b1;
                    bus.mem_raddr = if_idx;
                    bus.mem_waddr = if_idx;
                end
            end
            S_RMW: begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = rmw_word;
            end
            S_RESP: begin
                unique case (owner_q)
                    OWN_LD: bus.ld_ack = 1'b1;
                    OWN_D: begin
                        bus.d_ack = 1'b1;
                        bus.d_err = err_q;
                        if (rd_q)  bus.d_rdata = bus.mem_rdata;
                        if (err_q) bus.d_rdata = '0;
                    end
                    OWN_IF: begin
                        bus.if_ack   = 1'b1;
                        bus.if_rdata = bus.mem_rdata;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        // Reset is synchronous, so the in-flight state is still visible during
        // the reset cycle; blank the outputs so an aborted access never writes.
        if (reset) begin
            bus.mem_re    = 1'b0;
            bus.mem_we    = 1'b0;
            bus.mem_raddr = '0;
            bus.mem_waddr = '0;
            bus.mem_wdata = '0;
            bus.ld_ack    = 1'b0;
            bus.d_ack     = 1'b0;
            bus.d_err     = 1'b0;
            bus.if_ack    = 1'b0;
            bus.d_rdata   = '0;
            bus.if_rdata  = '0;
        end
    end
endmodule
